// File: rtl/iter_div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and default geometry.
package iter_div_unit_pkg;

  localparam int DIV_WIDTH_DEF = 32;
  localparam int DIV_TAG_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/iter_div_unit_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module iter_div_unit_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor always holds, so the top bit of diff is a clean borrow flag
  always_comb begin
    shifted  = {rem, dividend_bit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    next_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/iter_div_unit.sv
// Iterative restoring divider with valid/ready handshake, side-band tag, flush and
// divide-by-zero detection; one quotient bit per cycle on operand magnitudes.
module iter_div_unit
  import iter_div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF,
  parameter int TAG_W = DIV_TAG_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dq_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic             neg_q_q, neg_r_q;
  logic [TAG_W-1:0] tag_q;

  logic             accept;
  logic             x_neg, y_neg, y_zero;
  logic             last_step;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] fin_q;

  assign accept    = in_valid & in_ready;
  assign x_neg     = in_signed & in_x[WIDTH-1];
  assign y_neg     = in_signed & in_y[WIDTH-1];
  assign y_zero    = (in_y == '0);
  assign last_step = (state_q == ST_CALC) && (cnt_q == CNT_LAST);
  assign fin_q     = {dq_q[WIDTH-2:0], step_qbit};

  iter_div_unit_div_step #(.WIDTH(WIDTH)) u_step (
    .rem          (rem_q),
    .dividend_bit (dq_q[WIDTH-1]),
    .divisor      (dvs_q),
    .next_rem     (step_rem),
    .q_bit        (step_qbit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = y_zero ? ST_DONE : ST_CALC;
        ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_DONE;
        ST_DONE: begin
          if (accept)         state_d = y_zero ? ST_DONE : ST_CALC;
          else if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = ~flush & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
  end

  // ---- control and result registers (reset) ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      out_q   <= '0;
      out_r   <= '0;
      out_tag <= '0;
      out_dbz <= 1'b0;
    end else begin
      if (flush || accept || last_step) cnt_q <= '0;
      else if (state_q == ST_CALC)      cnt_q <= cnt_q + 1'b1;

      if (accept && y_zero) begin
        out_q   <= '1;
        out_r   <= in_x;
        out_tag <= in_tag;
        out_dbz <= 1'b1;
      end else if (last_step && !flush) begin
        out_q   <= cond_neg(fin_q, neg_q_q);
        out_r   <= cond_neg(step_rem, neg_r_q);
        out_tag <= tag_q;
        out_dbz <= 1'b0;
      end
    end
  end

  // ---- operand / iteration registers (data only) ----
  // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom
  always_ff @(posedge clk) begin
    if (accept) begin
      dq_q    <= cond_neg(in_x, x_neg);
      dvs_q   <= cond_neg(in_y, y_neg);
      rem_q   <= '0;
      neg_q_q <= x_neg ^ y_neg;
      neg_r_q <= x_neg;
      tag_q   <= in_tag;
    end else if (state_q == ST_CALC) begin
      dq_q  <= {dq_q[WIDTH-2:0], step_qbit};
      rem_q <= step_rem;
    end
  end

endmodule
